// File: rtl/fruta_spawner.sv
// fruta_spawner: places a fruit (cell code 4'b0010) on the first empty map
// cell found by a raster-ordered probe, starting from a free-running raster
// position captured when a spawn request is accepted.
// Optional feature macro: FRUTA_LFSR_EN (LFSR-randomised raster stride).
module fruta_spawner #(
    parameter int          MAPA_WIDTH  = 40,
    parameter int          MAPA_HEIGHT = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn_req,
    output logic       spawn_busy,
    output logic       spawn_done,
    output logic       spawn_fail,
    output logic       fruta_renable,
    output logic [9:0] fruta_rx,
    output logic [9:0] fruta_ry,
    input  logic [3:0] fruta_rdata,
    output logic       fruta_wenable,
    output logic [9:0] fruta_wx,
    output logic [9:0] fruta_wy,
    output logic [3:0] fruta_wdata,
    input  logic       fruta_wgnt
);

    localparam logic [9:0]  X_MAX  = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0]  Y_MAX  = 10'(MAPA_HEIGHT - 1);
    localparam logic [9:0]  X_SPAN = 10'(MAPA_WIDTH);
    localparam logic [19:0] CELLS  = 20'(MAPA_WIDTH * MAPA_HEIGHT);
    localparam logic [3:0]  FRUTA  = 4'b0010;

    // Elaboration-time parameter sanity checks
    if (MAPA_WIDTH < 4) begin : g_bad_width
        $error("fruta_spawner: MAPA_WIDTH must be >= 4");
    end
    if (MAPA_HEIGHT < 1) begin : g_bad_height
        $error("fruta_spawner: MAPA_HEIGHT must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("fruta_spawner: LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE,
        LE,
        CHECA,
        ESCREVE,
        FIM,
        FALHA
    } state_t;

    state_t      state;
    logic [9:0]  rx_cnt;
    logic [9:0]  ry_cnt;
    logic [9:0]  rx_next;
    logic [9:0]  ry_next;
    logic [10:0] x_sum;
    logic [9:0]  x_wrap;
    logic [2:0]  step;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic [9:0]  probe_x_next;
    logic [9:0]  probe_y_next;
    logic [19:0] probe_cnt;
    logic [19:0] cnt_next;

`ifdef FRUTA_LFSR_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Fibonacci LFSR (taps 16,14,13,11) stepping every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign step = {1'b0, lfsr[1:0]} + 3'd1;
`else
    assign step = 3'd1;
`endif

    // Next raster position; stride never exceeds the width, so one subtraction wraps x
    always_comb begin
        x_sum   = {1'b0, rx_cnt} + {8'd0, step};
        x_wrap  = x_sum[9:0] - X_SPAN;
        rx_next = x_sum[9:0];
        ry_next = ry_cnt;
        if (x_sum > {1'b0, X_MAX}) begin
            rx_next = x_wrap;
            ry_next = (ry_cnt == Y_MAX) ? '0 : ry_cnt + 10'd1;
        end
    end

    // Free-running raster counter that seeds each probe sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt <= '0;
            ry_cnt <= '0;
        end else begin
            rx_cnt <= rx_next;
            ry_cnt <= ry_next;
        end
    end

    // Next probe cell in raster order, wrapping at the map end
    always_comb begin
        probe_x_next = probe_x + 10'd1;
        probe_y_next = probe_y;
        if (probe_x == X_MAX) begin
            probe_x_next = '0;
            probe_y_next = (probe_y == Y_MAX) ? '0 : probe_y + 10'd1;
        end
    end

    assign cnt_next = probe_cnt + 20'd1;

    // Spawn FSM with registered strobes, coordinates and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            probe_x       <= '0;
            probe_y       <= '0;
            probe_cnt     <= '0;
            spawn_busy    <= 1'b0;
            spawn_done    <= 1'b0;
            spawn_fail    <= 1'b0;
            fruta_renable <= 1'b0;
            fruta_rx      <= '0;
            fruta_ry      <= '0;
            fruta_wenable <= 1'b0;
            fruta_wx      <= '0;
            fruta_wy      <= '0;
            fruta_wdata   <= '0;
        end else begin
            fruta_renable <= 1'b0;
            spawn_done    <= 1'b0;
            spawn_fail    <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        probe_x       <= rx_cnt;
                        probe_y       <= ry_cnt;
                        probe_cnt     <= '0;
                        spawn_busy    <= 1'b1;
                        fruta_renable <= 1'b1;
                        fruta_rx      <= rx_cnt;
                        fruta_ry      <= ry_cnt;
                        state         <= LE;
                    end
                end
                LE: begin
                    state <= CHECA;
                end
                CHECA: begin
                    probe_cnt <= cnt_next;
                    if (fruta_rdata == 4'b0000) begin
                        fruta_wenable <= 1'b1;
                        fruta_wx      <= probe_x;
                        fruta_wy      <= probe_y;
                        fruta_wdata   <= FRUTA;
                        state         <= ESCREVE;
                    end else if (cnt_next == CELLS) begin
                        spawn_fail <= 1'b1;
                        state      <= FALHA;
                    end else begin
                        probe_x       <= probe_x_next;
                        probe_y       <= probe_y_next;
                        fruta_renable <= 1'b1;
                        fruta_rx      <= probe_x_next;
                        fruta_ry      <= probe_y_next;
                        state         <= LE;
                    end
                end
                ESCREVE: begin
                    if (fruta_wgnt) begin
                        fruta_wenable <= 1'b0;
                        fruta_wdata   <= '0;
                        spawn_done    <= 1'b1;
                        state         <= FIM;
                    end
                end
                FIM: begin
                    spawn_busy <= 1'b0;
                    state      <= IDLE;
                end
                FALHA: begin
                    spawn_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    spawn_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fruta_spawner.sv
// Scoreboard bench for fruta_spawner (W=8, H=6, feature macro undefined).
// The reference model predicts every read, write and completion, with its cycle,
// from the raster position implied by the cycle count and a model copy of the map.
module tb_fruta_spawner;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spawn_req = 1'b0;
    logic       spawn_busy;
    logic       spawn_done;
    logic       spawn_fail;
    logic       fruta_renable;
    logic [9:0] fruta_rx;
    logic [9:0] fruta_ry;
    logic [3:0] fruta_rdata = 4'hF;
    logic       fruta_wenable;
    logic [9:0] fruta_wx;
    logic [9:0] fruta_wy;
    logic [3:0] fruta_wdata;
    logic       fruta_wgnt = 1'b1;

    fruta_spawner #(
        .MAPA_WIDTH (W),
        .MAPA_HEIGHT(H),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spawn_req    (spawn_req),
        .spawn_busy   (spawn_busy),
        .spawn_done   (spawn_done),
        .spawn_fail   (spawn_fail),
        .fruta_renable(fruta_renable),
        .fruta_rx     (fruta_rx),
        .fruta_ry     (fruta_ry),
        .fruta_rdata  (fruta_rdata),
        .fruta_wenable(fruta_wenable),
        .fruta_wx     (fruta_wx),
        .fruta_wy     (fruta_wy),
        .fruta_wdata  (fruta_wdata),
        .fruta_wgnt   (fruta_wgnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release; at edge k the raster holds (k-1) mod N
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [3:0] mem[N];
    logic [3:0] ref_map[N];

    // Map memory: loaded from the model map during reset, written by the DUT
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= ref_map[i];
        end else if (fruta_wenable && fruta_wgnt && fruta_wx < 10'(W) && fruta_wy < 10'(H)) begin
            mem[int'(fruta_wy) * W + int'(fruta_wx)] <= fruta_wdata;
        end
    end

    // Read port: data one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (fruta_renable && fruta_rx < 10'(W) && fruta_ry < 10'(H))
            fruta_rdata <= mem[int'(fruta_ry) * W + int'(fruta_rx)];
        else
            fruta_rdata <= 4'hF;
    end

    typedef struct {
        int kind;   // 0 read, 1 write commit, 2 done, 3 fail
        int x;
        int y;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  gnt_open = 0;

    // Grant driver: grant withheld until the model's chosen cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fruta_wgnt = (cyc >= gnt_open);
        end
    end

    task automatic reset_check();
        n_tests++;
        if ({spawn_busy, spawn_done, spawn_fail, fruta_renable, fruta_wenable} != 5'b0 ||
            fruta_rx != 0 || fruta_ry != 0 || fruta_wx != 0 || fruta_wy != 0 || fruta_wdata != 0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b fail=%b ren=%b wen=%b rx=%0d ry=%0d wx=%0d wy=%0d wdata=%h, required all zero",
                     spawn_busy, spawn_done, spawn_fail, fruta_renable, fruta_wenable,
                     fruta_rx, fruta_ry, fruta_wx, fruta_wy, fruta_wdata);
        end
    endtask

    task automatic check_event(input int kind, input int x, input int y);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind=%0d at (%0d,%0d) cyc %0d, required no event", kind, x, y, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind < 2 && (e.x != x || e.y != y))) begin
                n_fail++;
                $display("FAIL event_k%0d: got kind=%0d (%0d,%0d) cyc %0d, required kind=%0d (%0d,%0d) cyc %0d",
                         e.kind, kind, x, y, cyc, e.kind, e.x, e.y, e.cyc);
            end
        end
    endtask

    // Monitor: compares DUT activity against the expected-event queue
    initial begin
        @(negedge rst_n);
        #1;
        reset_check();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                reset_check();
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_event: kind=%0d (%0d,%0d) due cyc %0d, not seen by cyc %0d",
                             exp_q[0].kind, exp_q[0].x, exp_q[0].y, exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                n_tests++;
                if (spawn_busy != (cyc >= busy_lo && cyc <= busy_hi)) begin
                    n_fail++;
                    $display("FAIL busy: got %b at cyc %0d, required %b",
                             spawn_busy, cyc, (cyc >= busy_lo && cyc <= busy_hi));
                end
                if (fruta_renable) check_event(0, int'(fruta_rx), int'(fruta_ry));
                n_tests++;
                if (fruta_wenable) begin
                    if (fruta_wdata != 4'b0010) begin
                        n_fail++;
                        $display("FAIL wdata_active: got %h, required 2", fruta_wdata);
                    end
                    if (fruta_wgnt) begin
                        check_event(1, int'(fruta_wx), int'(fruta_wy));
                    end else begin
                        n_tests++;
                        if (!(exp_q.size() > 0 && exp_q[0].kind == 1 &&
                              exp_q[0].x == int'(fruta_wx) && exp_q[0].y == int'(fruta_wy))) begin
                            n_fail++;
                            $display("FAIL write_hold: wenable with (%0d,%0d) at cyc %0d, no matching pending write",
                                     fruta_wx, fruta_wy, cyc);
                        end
                    end
                end else if (fruta_wdata != 4'b0000) begin
                    n_fail++;
                    $display("FAIL wdata_idle: got %h, required 0", fruta_wdata);
                end
                if (spawn_done) check_event(2, 0, 0);
                if (spawn_fail) check_event(3, 0, 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        gnt_open = 0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Issue one request; the model predicts the full event sequence
    task automatic request(input int g, output int target);
        int c;
        int s;
        int idx;
        int w0;
        @(negedge clk);
        c = cyc;
        s = c % N;
        target = -1;
        w0 = 0;
        for (int i = 0; i < N; i++) begin
            idx = (s + i) % N;
            exp_q.push_back('{0, idx % W, idx / W, c + 1 + 2 * i});
            if (ref_map[idx] == 4'b0000) begin
                target = idx;
                w0 = c + 3 + 2 * i;
                break;
            end
        end
        busy_lo = c + 1;
        if (target >= 0) begin
            gnt_open = w0 + g;
            exp_q.push_back('{1, target % W, target / W, gnt_open});
            exp_q.push_back('{2, 0, 0, gnt_open + 1});
            busy_hi = gnt_open + 1;
            ref_map[target] = 4'b0010;
        end else begin
            exp_q.push_back('{3, 0, 0, c + 2 * N + 1});
            busy_hi = c + 2 * N + 1;
        end
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
    endtask

    // Request sampled at edge 'at' after reset release
    task automatic request_at(input int at, input int g, output int target);
        for (int k = 0; k < 200 && cyc != at - 1; k++) @(negedge clk);
        request(g, target);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && cyc > busy_hi) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: %0d events pending at cyc %0d, required none", exp_q.size(), cyc);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < N; i++) ref_map[i] = 4'b0000;
    endtask

    initial begin
        int t;
        int dens[4];
        dens = '{30, 60, 90, 100};

        // Empty map, request on edge 12 -> start (3,1)
        clear_map();
        do_reset();
        request_at(12, 0, t);
        wait_idle();

        // (3,1),(4,1) snake -> write (5,1)
        clear_map();
        ref_map[11] = 4'b1000;
        ref_map[12] = 4'b1000;
        do_reset();
        request_at(12, 0, t);
        wait_idle();

        // Start (7,5) obstacle -> wrap to (0,0)
        clear_map();
        ref_map[47] = 4'b0001;
        do_reset();
        request_at(48, 0, t);
        wait_idle();

        // Full map -> fail after 48 reads
        for (int i = 0; i < N; i++) ref_map[i] = 4'($urandom_range(1, 15));
        do_reset();
        request_at(5, 0, t);
        wait_idle();

        // Grant withheld 5 cycles, plus an ignored request while busy
        clear_map();
        do_reset();
        request_at(20, 5, t);
        repeat (2) @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);

        // Reset during ESCREVE, then a fresh request from the raster value
        clear_map();
        do_reset();
        request_at(9, 20, t);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        gnt_open = 0;
        if (t >= 0) ref_map[t] = 4'b0000;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        request_at($urandom_range(3, 40), 0, t);
        wait_idle();

        // Randomized epochs with increasing occupancy
        for (int ep = 0; ep < 4; ep++) begin
            for (int i = 0; i < N; i++)
                ref_map[i] = ($urandom_range(0, 99) < dens[ep]) ? 4'($urandom_range(1, 15)) : 4'b0000;
            do_reset();
            for (int tr = 0; tr < 8; tr++) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                request($urandom_range(0, 3), t);
                wait_idle();
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fruta_spawner.md
# fruta_spawner

- Places a new fruit (cell code 4'b0010) on an empty map cell whenever the snake update stage reports a fruit was eaten.
- Sits upstream of the map memory, beside the snake update stage:
  - takes a one-cycle spawn request;
  - probes the map through its own read port;
  - writes the fruit through an arbitrated write request;
  - reports completion or failure.
- Holds `spawn_busy` while working; the top level uses it to keep the update stage in IDLE, so no map re-check is needed.

## Interface
- `MAPA_WIDTH`, 40: map columns; must be ≥ 4.
- `MAPA_HEIGHT`, 30: map rows; must be ≥ 1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero. Used only with `FRUTA_LFSR_EN`.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `spawn_req` in 1: request pulse; sampled only in IDLE.
- `spawn_busy` out 1: high from the edge accepting a request until return to IDLE.
- `spawn_done` out 1: one-cycle pulse; fruit written.
- `spawn_fail` out 1: one-cycle pulse; no empty cell exists.
- `fruta_renable` out 1: map read strobe.
- `fruta_rx`, `fruta_ry` out 10 each: read coordinates.
- `fruta_rdata` in 4: cell contents, valid the cycle after `fruta_renable` is high.
- `fruta_wenable` out 1: write request; held until granted.
- `fruta_wx`, `fruta_wy` out 10 each: write coordinates.
- `fruta_wdata` out 4: 4'b0010 while `fruta_wenable` is high, else 0.
- `fruta_wgnt` in 1: arbiter grant; the write commits in a cycle where `fruta_wenable` and `fruta_wgnt` are both high.

## Operation
- Cell codes:
  - 4'b0000: empty.
  - 4'b0001: obstacle.
  - 4'b0010: fruit.
  - 1xxx: snake.
  - Only 4'b0000 accepts a fruit.
- Raster counter (`rx_cnt`, `ry_cnt`):
  - free-running from reset; advances `step` cells every edge; x wraps at `MAPA_WIDTH` and carries into y; y wraps at `MAPA_HEIGHT`.
  - Without the macro, `step` = 1.
- State machine:
  - IDLE: all strobes low. If `spawn_req`=1: latch raster value (pre-increment) into `probe_x`/`probe_y`; clear 20-bit `probe_cnt`; set busy; go to LE.
  - LE: drive `fruta_renable`=1 and `fruta_rx`/`fruta_ry` = probe for one cycle; go to CHECA.
  - CHECA: sample `fruta_rdata`; increment `probe_cnt`.
    - Data == 0 → ESCREVE.
    - Else, if `probe_cnt` == `MAPA_WIDTH`*`MAPA_HEIGHT` → FALHA.
    - Else advance probe one cell (x+1, wrap to 0 with y+1; y wraps to 0) → LE.
  - ESCREVE: `fruta_wenable`=1, `fruta_wx`/`fruta_wy` = probe, `fruta_wdata`=4'b0010. Stays until `fruta_wgnt`=1, then → FIM.
  - FIM: `spawn_done`=1 one cycle → IDLE.
  - FALHA: `spawn_fail`=1 one cycle → IDLE.
- `spawn_req` outside IDLE is ignored; it is not queued.
- Arithmetic: x/y compares against `MAPA_WIDTH-1` and `MAPA_HEIGHT-1` are 10-bit unsigned; no modulo operators.

## Timing
- Reset (async assert): all outputs 0, state IDLE, raster (0,0), probe (0,0), `probe_cnt` 0, LFSR = `LFSR_SEED`. Release is synchronous to the first edge.
- Request sampled at edge 0:
  - `fruta_renable` high in cycle 1;
  - rdata sampled at the end of cycle 2;
  - `fruta_wenable` high from cycle 3.
- With `fruta_wgnt` held high: `spawn_done` in cycle 4, busy low from cycle 5.
- Each occupied cell adds 2 cycles. Each grant-withheld cycle adds 1.
- Full map: `spawn_fail` after exactly 2·W·H+1 cycles of busy, with no write issued.
- Reset mid-operation: returns to IDLE immediately; an in-flight `fruta_wenable` drops asynchronously.

## Configuration
- `FRUTA_LFSR_EN`
  - Defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every edge; raster `step` = 1 + `lfsr[1:0]` (1..4 cells, carry/wrap by subtraction).
  - Undefined: LFSR absent; `step` = 1; placement fully deterministic from cycle count.

## Test plan
All cases use W=8, H=6, macro undefined.
- Empty map, `fruta_wgnt`=1, `spawn_req` on the 12th edge after reset release → start (3,1); read (3,1); write (3,1) with data 4'b0010; `spawn_done` 4 cycles after the request.
- Same request, but map cells (3,1) and (4,1) = 4'b1000 → reads (3,1), (4,1), (5,1); write (5,1); done at cycle 8.
- Start (7,5) occupied by obstacle 4'b0001 → probe wraps to (0,0); write (0,0).
- All 48 cells nonzero → 48 reads, no `fruta_wenable`, `spawn_fail` pulse at cycle 97, busy then low.
- `fruta_wgnt` low for 5 cycles during ESCREVE → `fruta_wenable`/coords/data stable throughout; done 1 cycle after grant. A second `spawn_req` while busy produces no extra write.
- `rst_n` pulsed low during ESCREVE → `fruta_wenable` 0 immediately; next request restarts from the raster value.
